// File: rtl/store_pack.sv
// Store packer: turns MEM-stage sw/sh/sb requests into lane-positioned word writes, queued in a 2-entry buffer.
// With STORE_ALIGN_CHECK_EN defined, misaligned sw/sh raise exc_ades/exc_badvaddr instead of being queued.
module store_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
`ifdef STORE_ALIGN_CHECK_EN
    output logic        exc_ades,
    output logic [31:0] exc_badvaddr,
`endif
    output logic        sb_empty
);

    localparam logic [1:0] OP_SW  = 2'b00;
    localparam logic [1:0] OP_SH  = 2'b01;
    localparam logic [1:0] OP_SB  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic [1:0]  count_reg, count_next;
    logic        wr_ptr_reg, rd_ptr_reg;
    logic [31:0] entry_addr  [2];
    logic [31:0] entry_wdata [2];
    logic [3:0]  entry_be    [2];

    logic [31:0] pack_addr;
    logic [31:0] pack_wdata;
    logic [3:0]  pack_be;
    logic        misaligned;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        pack_addr  = {st_addr[31:2], 2'b00};
        pack_wdata = st_data;
        pack_be    = 4'b1111;
        case (st_op)
            OP_SH: begin
                pack_wdata = {st_data[15:0], st_data[15:0]};
                pack_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                pack_wdata = {4{st_data[7:0]}};
                pack_be    = 4'b0001 << st_addr[1:0];
            end
            default: begin
                pack_wdata = st_data;
                pack_be    = 4'b1111;
            end
        endcase
    end

`ifdef STORE_ALIGN_CHECK_EN
    assign misaligned = ((st_op == OP_SW) && (st_addr[1:0] != 2'b00)) ||
                        ((st_op == OP_SH) && st_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    // Ready depends only on registered occupancy, so a same-cycle ack never frees a slot early.
    assign st_ready = (count_reg != 2'd2);
    assign mem_req  = (count_reg != 2'd0);
    assign sb_empty = (count_reg == 2'd0);
    assign accept   = st_valid && st_ready;
    assign push     = accept && (st_op != OP_RSV) && !misaligned;
    assign pop      = mem_req && mem_ack;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_addr[gi]  <= '0;
                    entry_wdata[gi] <= '0;
                    entry_be[gi]    <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_addr[gi]  <= pack_addr;
                    entry_wdata[gi] <= pack_wdata;
                    entry_be[gi]    <= pack_be;
                end
            end
        end
    endgenerate

    // Head is forced to zero while empty so stale slots never leak onto the bus.
    assign mem_addr  = mem_req ? entry_addr[rd_ptr_reg]  : '0;
    assign mem_wdata = mem_req ? entry_wdata[rd_ptr_reg] : '0;
    assign mem_be    = mem_req ? entry_be[rd_ptr_reg]    : '0;

`ifdef STORE_ALIGN_CHECK_EN
    logic        exc_ades_reg;
    logic [31:0] exc_badvaddr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_ades_reg     <= 1'b0;
            exc_badvaddr_reg <= '0;
        end else begin
            exc_ades_reg <= accept && misaligned;
            if (accept && misaligned) exc_badvaddr_reg <= st_addr;
        end
    end

    assign exc_ades     = exc_ades_reg;
    assign exc_badvaddr = exc_badvaddr_reg;
`endif

endmodule
